// File: rtl/pad_cond_pkg.sv
// Shared definitions for the pad input conditioner: default channel
// configuration and a constant-evaluable ceiling log2 helper.
package pad_cond_pkg;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int FILT_LEN_DEF     = 4;
  localparam int GLITCH_CNT_W_DEF = 8;

  // Ceiling log2; returns 0 for n <= 1 so a single-cycle filter has no counter.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pad_cond_channel.sv
// One pad input channel: synchronizer chain, persistence-count glitch
// filter, registered rise/fall strobes and, when PAD_COND_GLITCH_CNT_EN is
// defined, a saturating counter of rejected glitches.
module pad_cond_channel
  import pad_cond_pkg::*;
#(
  parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int   FILT_LEN     = FILT_LEN_DEF,
  parameter logic RST_VAL      = 1'b0
`ifdef PAD_COND_GLITCH_CNT_EN
  ,
  parameter int   GLITCH_CNT_W = GLITCH_CNT_W_DEF
`endif
) (
  input  logic i_CLK,
  input  logic i_RSTN,
  input  logic i_PAD_IN,
  output logic o_LEVEL,
  output logic o_RISE,
  output logic o_FALL
`ifdef PAD_COND_GLITCH_CNT_EN
  ,
  input  logic                    i_GLITCH_CLR,
  output logic [GLITCH_CNT_W-1:0] o_GLITCH_CNT
`endif
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_s;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   mismatch;
  logic                   accept;
`ifdef PAD_COND_GLITCH_CNT_EN
  logic                   glitch;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

  // Counter saturates instead of wrapping so a noisy line stays visibly noisy.
  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (&v) ? v : v + GLITCH_CNT_W'(1);
  endfunction
`endif

  // Plain flop chain for metastability settling; nothing between stages.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) sync_chain <= {SYNC_STAGES{RST_VAL}};
    else         sync_chain <= {sync_chain[SYNC_STAGES-2:0], i_PAD_IN};
  end

  assign sync_s   = sync_chain[SYNC_STAGES-1];
  assign mismatch = sync_s ^ level_q;

  if (FILT_LEN == 1) begin : g_no_filt
    // Any synchronized change is accepted on the next edge.
    assign accept = mismatch;
`ifdef PAD_COND_GLITCH_CNT_EN
    assign glitch = 1'b0;
`endif
  end else begin : g_filt
    localparam int CNT_W = clog2(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);
    logic [CNT_W-1:0] cnt_q;

    assign accept = mismatch && (cnt_q == CNT_MAX);
`ifdef PAD_COND_GLITCH_CNT_EN
    // Level fell back before persisting long enough: a rejected glitch.
    assign glitch = !mismatch && (cnt_q != '0);
`endif

    // Persistence counter: counts consecutive cycles of disagreement.
    always_ff @(posedge i_CLK) begin
      if (!i_RSTN)                 cnt_q <= '0;
      else if (!mismatch || accept) cnt_q <= '0;
      else                          cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Accepted level and one-cycle strobes registered together.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      if (accept) level_q <= sync_s;
      rise_q <= accept &  sync_s;
      fall_q <= accept & ~sync_s;
    end
  end

  assign o_LEVEL = level_q;
  assign o_RISE  = rise_q;
  assign o_FALL  = fall_q;

`ifdef PAD_COND_GLITCH_CNT_EN
  // Glitch tally; a clear takes priority over a same-cycle increment.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN || i_GLITCH_CLR) glitch_cnt_q <= '0;
    else if (glitch)             glitch_cnt_q <= sat_inc(glitch_cnt_q);
  end

  assign o_GLITCH_CNT = glitch_cnt_q;
`endif

endmodule

// File: rtl/pad_input_conditioner.sv
// Multi-channel pad input conditioner: N_CH independent copies of
// pad_cond_channel. Defining PAD_COND_GLITCH_CNT_EN adds i_GLITCH_CLR and
// the packed per-channel o_GLITCH_CNT bus (channel i at [i*W +: W]).
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int              N_CH         = 8,
  parameter int              SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int              FILT_LEN     = FILT_LEN_DEF,
  parameter logic [N_CH-1:0] RST_VAL      = {N_CH{1'b0}},
  parameter int              GLITCH_CNT_W = GLITCH_CNT_W_DEF
) (
  input  logic            i_CLK,
  input  logic            i_RSTN,
  input  logic [N_CH-1:0] i_PAD_IN,
  output logic [N_CH-1:0] o_LEVEL,
  output logic [N_CH-1:0] o_RISE,
  output logic [N_CH-1:0] o_FALL
`ifdef PAD_COND_GLITCH_CNT_EN
  ,
  input  logic                         i_GLITCH_CLR,
  output logic [N_CH*GLITCH_CNT_W-1:0] o_GLITCH_CNT
`endif
);

  // Reject configurations the channel logic cannot represent.
  if (N_CH < 1 || SYNC_STAGES < 2 || FILT_LEN < 1 || GLITCH_CNT_W < 1) begin : g_param_err
    $error("pad_input_conditioner: illegal parameter combination");
  end

  // One fully independent conditioner per pad.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pad_cond_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILT_LEN     (FILT_LEN),
      .RST_VAL      (RST_VAL[i])
`ifdef PAD_COND_GLITCH_CNT_EN
      ,
      .GLITCH_CNT_W (GLITCH_CNT_W)
`endif
    ) u_ch (
      .i_CLK        (i_CLK),
      .i_RSTN       (i_RSTN),
      .i_PAD_IN     (i_PAD_IN[i]),
      .o_LEVEL      (o_LEVEL[i]),
      .o_RISE       (o_RISE[i]),
      .o_FALL       (o_FALL[i])
`ifdef PAD_COND_GLITCH_CNT_EN
      ,
      .i_GLITCH_CLR (i_GLITCH_CLR),
      .o_GLITCH_CNT (o_GLITCH_CNT[i*GLITCH_CNT_W +: GLITCH_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner: an 8-channel instance
// (SYNC_STAGES=2, FILT_LEN=4, RST_VAL=8'h81) and a 2-channel instance
// (SYNC_STAGES=3, FILT_LEN=1, RST_VAL=2'b10) sharing clock and reset.
module tb_pad_input_conditioner;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  pad, level, rise, fall;
  logic [1:0]  pad2, level2, rise2, fall2;
`ifdef PAD_COND_GLITCH_CNT_EN
  logic        clr;
  logic [63:0] gcnt;
  logic [15:0] gcnt2;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  int          rise_at;
  int          fall_at;
  logic [7:0]  seen;

  always #5 clk = ~clk;

  pad_input_conditioner #(
    .N_CH(8), .SYNC_STAGES(2), .FILT_LEN(4), .RST_VAL(8'h81), .GLITCH_CNT_W(8)
  ) dut (
    .i_CLK(clk), .i_RSTN(rstn), .i_PAD_IN(pad),
    .o_LEVEL(level), .o_RISE(rise), .o_FALL(fall)
`ifdef PAD_COND_GLITCH_CNT_EN
    , .i_GLITCH_CLR(clr), .o_GLITCH_CNT(gcnt)
`endif
  );

  pad_input_conditioner #(
    .N_CH(2), .SYNC_STAGES(3), .FILT_LEN(1), .RST_VAL(2'b10), .GLITCH_CNT_W(8)
  ) dut2 (
    .i_CLK(clk), .i_RSTN(rstn), .i_PAD_IN(pad2),
    .o_LEVEL(level2), .o_RISE(rise2), .o_FALL(fall2)
`ifdef PAD_COND_GLITCH_CNT_EN
    , .i_GLITCH_CLR(clr), .o_GLITCH_CNT(gcnt2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    pad  = 8'h00;
    pad2 = 2'b00;
`ifdef PAD_COND_GLITCH_CNT_EN
    clr  = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_level", 64'(level), 64'h81);
    chk("rst_rise", 64'(rise), 64'h0);
    chk("rst_fall", 64'(fall), 64'h0);
    chk("rst_level2", 64'(level2), 64'h2);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("rst_gcnt", gcnt, 64'h0);
`endif

    // Release with pads matching the reset levels: nothing should move.
    rstn = 1'b1;
    pad  = 8'h81;
    pad2 = 2'b10;
    seen = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen |= rise | fall | (level ^ 8'h81);
    end
    chk("idle_quiet", 64'(seen), 64'h0);

    // FILT_LEN=1, SYNC_STAGES=3: level follows after E0+3.
    pad2[0] = 1'b1;
    repeat (3) tick();
    chk("f1_level_early", 64'(level2), 64'h2);
    tick();
    chk("f1_level", 64'(level2), 64'h3);
    chk("f1_rise", 64'(rise2), 64'h1);
    tick();
    chk("f1_rise_one_cycle", 64'(rise2), 64'h0);

    // FILT_LEN=1: a single-cycle low pulse passes straight through.
    pad2[1] = 1'b0;
    rise_at = -1;
    fall_at = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) pad2[1] = 1'b1;
      if (fall2[1]) fall_at = k;
      if (rise2[1]) rise_at = k;
    end
    chk("f1_pulse_fall_at", 64'(fall_at), 64'd3);
    chk("f1_pulse_rise_at", 64'(rise_at), 64'd4);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("f1_gcnt", 64'(gcnt2), 64'h0);
`endif

    // Clean rise on ch3: E0 capture, level at E0+5.
    pad[3] = 1'b1;
    repeat (5) tick();
    chk("rise3_early", 64'(level), 64'h81);
    chk("rise3_no_strobe_early", 64'(rise), 64'h0);
    tick();
    chk("rise3_level", 64'(level), 64'h89);
    chk("rise3_strobe", 64'(rise), 64'h08);
    chk("rise3_no_fall", 64'(fall), 64'h0);
    tick();
    chk("rise3_one_cycle", 64'(rise), 64'h0);

    // Clean fall on ch0 to bring it low.
    pad[0] = 1'b0;
    repeat (6) tick();
    chk("fall0_level", 64'(level), 64'h88);
    chk("fall0_strobe", 64'(fall), 64'h01);
    chk("fall0_no_rise", 64'(rise), 64'h0);
    tick();
    chk("fall0_one_cycle", 64'(fall), 64'h0);

    // 3-cycle pulse on ch0 is rejected.
    pad[0] = 1'b1;
    seen = 8'h00;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 2) pad[0] = 1'b0;
      seen |= rise | fall | (level ^ 8'h88);
    end
    chk("glitch3_quiet", 64'(seen), 64'h0);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("glitch3_gcnt", gcnt, 64'h1);
`endif

    // 4-cycle pulse on ch0 is accepted: rise at E0+5, fall at E0+9.
    pad[0] = 1'b1;
    rise_at = -1;
    fall_at = -1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 3) pad[0] = 1'b0;
      if (rise[0]) rise_at = k;
      if (fall[0]) fall_at = k;
    end
    chk("pulse4_rise_at", 64'(rise_at), 64'd5);
    chk("pulse4_fall_at", 64'(fall_at), 64'd9);
    chk("pulse4_level_after", 64'(level), 64'h88);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("pulse4_gcnt", gcnt, 64'h1);
`endif

    // Raise ch2, then ch1 up and ch2 down on the same edge.
    pad[2] = 1'b1;
    repeat (7) tick();
    chk("raise2_level", 64'(level), 64'h8C);
    pad[1] = 1'b1;
    pad[2] = 1'b0;
    repeat (6) tick();
    chk("simul_rise", 64'(rise), 64'h02);
    chk("simul_fall", 64'(fall), 64'h04);
    chk("simul_level", 64'(level), 64'h8A);
    tick();

    // ch5 one-cycle glitch lands on the edge where the clear is high.
    pad[5] = 1'b1;
    tick();
    pad[5] = 1'b0;
    tick();
    tick();
`ifdef PAD_COND_GLITCH_CNT_EN
    clr = 1'b1;
`endif
    tick();
`ifdef PAD_COND_GLITCH_CNT_EN
    clr = 1'b0;
`endif
    repeat (2) tick();
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("clr_wins_gcnt", gcnt, 64'h0);
`endif
    pad[5] = 1'b1;
    tick();
    pad[5] = 1'b0;
    repeat (4) tick();
    chk("glitch5_level", 64'(level), 64'h8A);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("glitch5_gcnt", gcnt, 64'h0000_0100_0000_0000);
`endif

    // ch6 mismatch reaches cnt=2, then a one-edge reset.
    pad[6] = 1'b1;
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    chk("midrst_level", 64'(level), 64'h81);
    chk("midrst_rise", 64'(rise), 64'h0);
    chk("midrst_fall", 64'(fall), 64'h0);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("midrst_gcnt", gcnt, 64'h0);
`endif
    rstn = 1'b1;
    repeat (5) tick();
    chk("midrst_early", 64'(level), 64'h81);
    tick();
    chk("midrst_level_after", 64'(level), 64'hCA);
    chk("midrst_rise_after", 64'(rise), 64'h4A);
    chk("midrst_fall_after", 64'(fall), 64'h01);
    tick();

    // 300 one-cycle glitches on ch4 saturate its counter.
    seen = 8'h00;
    for (int g = 0; g < 300; g++) begin
      pad[4] = 1'b1;
      tick();
      seen |= rise | fall | (level ^ 8'hCA);
      pad[4] = 1'b0;
      tick();
      seen |= rise | fall | (level ^ 8'hCA);
    end
    repeat (4) tick();
    chk("sat_quiet", 64'(seen), 64'h0);
`ifdef PAD_COND_GLITCH_CNT_EN
    chk("sat_gcnt", gcnt, 64'h0000_00FF_0000_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_input_conditioner.md
Name: pad_input_conditioner

Overview:
- Multi-channel conditioner for asynchronous pad inputs: per channel, a synchronizer chain, a persistence-count glitch filter, and single-cycle rise/fall strobes.
- Generalises the single-bit reset glitch synchronizer into N channels with configurable depth.
- Sits between the input pad cells (phic/phis outputs) and khu_sensor_top: sensor DRDY, MISO-side status lines, UART RX, external buttons.

Parameters:
- N_CH, 8, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchronizer flop depth (>=2)
- FILT_LEN, 4, consecutive synchronized cycles a new level must persist before acceptance (>=1)
- RST_VAL, {N_CH{1'b0}}, N_CH-bit per-channel reset level for sync chain and o_LEVEL
- GLITCH_CNT_W, 8, glitch counter width (used only with the optional feature)

Ports:
- i_CLK  input  1  system clock
- i_RSTN  input  1  reset, synchronous, active-low
- i_PAD_IN  input  N_CH  asynchronous pad-side inputs
- o_LEVEL  output  N_CH  filtered, synchronized level
- o_RISE  output  N_CH  one-cycle strobe when o_LEVEL[i] goes 0->1
- o_FALL  output  N_CH  one-cycle strobe when o_LEVEL[i] goes 1->0
- i_GLITCH_CLR  input  1  clear all glitch counters (present only with the optional feature)
- o_GLITCH_CNT  output  N_CH*GLITCH_CNT_W  per-channel glitch counts, channel i at [i*W +: W] (present only with the optional feature)

Behaviour:
- Clocking and reset: one clock, i_CLK. Reset is synchronous, active-low on i_RSTN. All state updates only on the rising edge of i_CLK.
- Reset values (i_RSTN low at an edge):
  - every sync stage of channel i = RST_VAL[i]
  - o_LEVEL = RST_VAL
  - persistence counters = 0
  - o_RISE = 0, o_FALL = 0
  - glitch counters = 0
- Sync chain, per channel:
  - stage1 <= i_PAD_IN[i]; stage k <= stage k-1.
  - s[i] denotes the last stage. No logic is placed between stages.
- Filter, per channel, with counter cnt of width clog2(FILT_LEN):
  - s != o_LEVEL and cnt == FILT_LEN-1: o_LEVEL <= s, cnt <= 0, assert o_RISE or o_FALL per new value.
  - s != o_LEVEL and cnt < FILT_LEN-1: cnt <= cnt+1.
  - s == o_LEVEL: cnt <= 0. If cnt was nonzero, this is a glitch event.
- Latency: a pad level captured by stage1 at edge E0 appears on o_LEVEL after edge E0+SYNC_STAGES+FILT_LEN-1. Strobes are asserted in the same cycle as the o_LEVEL change.
- Glitch rejection, in synchronized cycles:
  - pulse shorter than FILT_LEN is rejected, with no strobe
  - pulse of FILT_LEN or longer is accepted
- Strobes: exactly one cycle wide. o_RISE[i] and o_FALL[i] are never both high. Channels are fully independent, so simultaneous events on different channels each produce their own strobe in the same cycle.
- FILT_LEN == 1: cnt is 0 width. o_LEVEL follows s with one cycle of delay. Glitch events never occur.
- Reset mid-filter: partial count is discarded. After release, a full FILT_LEN persistence is required again.
- Outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: PAD_COND_GLITCH_CNT_EN.
- Defined:
  - i_GLITCH_CLR and o_GLITCH_CNT are present.
  - Each glitch event increments the channel counter, saturating at 2^GLITCH_CNT_W-1.
  - i_GLITCH_CLR high at an edge sets all counters to 0. Clear wins over a simultaneous increment.
- Not defined: ports and counters are absent; the filter behaviour is identical.

Decomposition:
- Shared package pad_cond_pkg:
  - clog2 function
  - default constants SYNC_STAGES_DEF=2, FILT_LEN_DEF=4, GLITCH_CNT_W_DEF=8
- Sub-module pad_cond_channel: one channel covering sync chain, filter, strobes and optional counter. Instantiated N_CH times by a generate loop in the top.

Test Plan:
- Reset: RST_VAL=8'h81, i_RSTN low for 3 edges with i_PAD_IN=8'h00 -> o_LEVEL=8'h81, o_RISE=o_FALL=0, o_GLITCH_CNT=0.
- Clean rise: SYNC_STAGES=2, FILT_LEN=4, i_PAD_IN[3] 0->1 captured at E0 -> o_LEVEL[3]=1 after E0+5, o_RISE[3]=1 for exactly that cycle, other channels quiet.
- Glitch: i_PAD_IN[0] high for 3 cycles, then low -> o_LEVEL[0] stays 0, no strobe, glitch count ch0=1. A 4-cycle pulse -> o_LEVEL[0] pulses high, o_RISE then o_FALL.
- Simultaneous events: ch1 0->1 and ch2 1->0 at the same edge -> o_RISE[1] and o_FALL[2] in the same cycle. Then i_GLITCH_CLR together with a ch5 glitch -> ch5 count reads 0.
- Reset mid-filter: ch6 mismatch held until cnt=2, then i_RSTN low for 1 edge -> o_LEVEL[6]=RST_VAL[6], cnt=0. After release, acceptance takes a full 4 cycles.
- Edge configs:
  - FILT_LEN=1, SYNC_STAGES=3: change at E0 -> o_LEVEL after E0+3
  - 300 glitches on one channel with W=8 -> count saturates at 255
